des_key_sched: RTL and testbench

//  Iterative DES key schedule. Accepts a 64-bit key and produces the 16 round subkeys
//  (48 bit) one per handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.

---
 rtl/des_pkg.sv | 68 ++++++
 rtl/des_pc2.sv | 17 +
 rtl/des_key_sched.sv | 135 +++++++++++++
 tb/tb_des_key_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: permutation tables, shift schedules, FSM states.
package des_pkg;

    localparam int DES_KEY_W    = 64;
    localparam int DES_SUBKEY_W = 48;
    localparam int DES_HALF_W   = 28;
    localparam int DES_CD_W     = 56;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // PC-1: DES key bit numbers (1 = MSB) feeding C (first 28) and D (last 28).
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    // PC-2: CD bit numbers (1 = MSB of C) selected into the 48-bit subkey.
    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // Per-round rotate amounts; decrypt round 0 uses the unrotated C0/D0.
    localparam logic [1:0] SHL [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };
    localparam logic [1:0] SHR [16] = '{
        2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // PC-1 selection; result bit 55 is C bit 1, bit 0 is D bit 28.
    function automatic logic [DES_CD_W-1:0] pc1_select(input logic [DES_KEY_W-1:0] key);
        logic [DES_CD_W-1:0] cd;
        cd = '0;
        for (int j = 0; j < DES_CD_W; j++) begin
            cd[6'(55 - j)] = key[6'(64 - PC1[j[5:0]])];
        end
        return cd;
    endfunction

    function automatic logic [DES_HALF_W-1:0] rotl28(input logic [DES_HALF_W-1:0] x,
                                                     input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [DES_HALF_W-1:0] rotr28(input logic [DES_HALF_W-1:0] x,
                                                     input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection from a 56-bit C/D pair down to a 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [DES_CD_W-1:0]     cd_i,
    output logic [DES_SUBKEY_W-1:0] subkey_o
);

    // Pure bit selection; subkey bit 47 is DES subkey bit 1.
    always_comb begin
        subkey_o = '0;
        for (int j = 0; j < DES_SUBKEY_W; j++) begin
            subkey_o[6'(47 - j)] = cd_i[6'(56 - PC2[j[5:0]])];
        end
    end

endmodule

// File: rtl/des_key_sched.sv
// Iterative DES key schedule: one 48-bit subkey per handshake, in encrypt or decrypt order.
module des_key_sched
    import des_pkg::*;
#(
    parameter int PARITY_CHECK = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DES_KEY_W-1:0]    key_in,
    input  logic                    decrypt,
    input  logic                    key_valid,
    output logic                    key_ready,
    output logic                    key_parity_err,
    output logic [DES_SUBKEY_W-1:0] subkey,
    output logic [3:0]              subkey_round,
    output logic                    subkey_last,
    output logic                    subkey_valid,
    input  logic                    subkey_ready
);

    sched_state_e state_q, state_d;

    logic [DES_HALF_W-1:0]   c_q, d_q, c_d, d_d;
    logic [DES_HALF_W-1:0]   src_c, src_d, c_rot, d_rot;
    logic [DES_SUBKEY_W-1:0] subkey_q, subkey_d, pc2_out;
    logic [DES_CD_W-1:0]     pc1_out;
    logic [3:0]              round_q, round_d, round_nxt;
    logic                    valid_q, valid_d;
    logic                    last_q, last_d;
    logic                    dec_q, dec_d;
    logic                    perr_q, perr_d;
    logic                    load, rot_right;
    logic [1:0]              shamt;
    logic [7:0]              byte_even;
    logic                    parity_bad;

    assign pc1_out   = pc1_select(key_in);
    assign round_nxt = round_q + 4'd1;

    assign byte_even = {~^key_in[63:56], ~^key_in[55:48], ~^key_in[47:40], ~^key_in[39:32],
                        ~^key_in[31:24], ~^key_in[23:16], ~^key_in[15:8],  ~^key_in[7:0]};
    assign parity_bad = (PARITY_CHECK != 0) && (|byte_even);

    // Next-state and datapath control: load a fresh key in IDLE, step one round per accept in RUN.
    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        valid_d   = valid_q;
        last_d    = last_q;
        dec_d     = dec_q;
        perr_d    = perr_q;
        load      = 1'b0;
        rot_right = dec_q;
        src_c     = c_q;
        src_d     = d_q;
        shamt     = 2'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid) begin
                    state_d        = ST_RUN;
                    {src_c, src_d} = pc1_out;
                    rot_right      = decrypt;
                    shamt          = decrypt ? SHR[0] : SHL[0];
                    load           = 1'b1;
                    round_d        = 4'd0;
                    valid_d        = 1'b1;
                    last_d         = 1'b0;
                    dec_d          = decrypt;
                    perr_d         = parity_bad;
                end
            end
            ST_RUN: begin
                if (subkey_ready) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        round_d = 4'd0;
                    end else begin
                        shamt   = dec_q ? SHR[round_nxt] : SHL[round_nxt];
                        load    = 1'b1;
                        round_d = round_nxt;
                        last_d  = (round_nxt == 4'd15);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign c_rot = rot_right ? rotr28(src_c, shamt) : rotl28(src_c, shamt);
    assign d_rot = rot_right ? rotr28(src_d, shamt) : rotl28(src_d, shamt);

    des_pc2 u_pc2 (
        .cd_i     ({c_rot, d_rot}),
        .subkey_o (pc2_out)
    );

    assign c_d      = load ? c_rot   : c_q;
    assign d_d      = load ? d_rot   : d_q;
    assign subkey_d = load ? pc2_out : subkey_q;

    // All schedule state; stalls simply leave every register unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            c_q      <= '0;
            d_q      <= '0;
            subkey_q <= '0;
            round_q  <= 4'd0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            dec_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            subkey_q <= subkey_d;
            round_q  <= round_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            dec_q    <= dec_d;
            perr_q   <= perr_d;
        end
    end

    assign key_ready      = (state_q == ST_IDLE);
    assign key_parity_err = perr_q;
    assign subkey         = subkey_q;
    assign subkey_round   = round_q;
    assign subkey_last    = last_q;
    assign subkey_valid   = valid_q;

endmodule

// File: tb/tb_des_key_sched.sv
// Randomized bench for des_key_sched against a bit-level DES key schedule model.
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] key_in;
    logic        decrypt;
    logic        key_valid;
    logic        key_ready;
    logic        key_parity_err;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_last;
    logic        subkey_valid;
    logic        subkey_ready;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] KEY_REF = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
    localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

    localparam int PC1T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int PC2T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int ROTT [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    typedef struct {
        logic [47:0] key;
        logic [3:0]  round;
        logic        last;
    } exp_t;

    exp_t        expQ[$];
    logic [47:0] capFirst;
    logic [47:0] capLast;

    des_key_sched #(.PARITY_CHECK(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .key_in         (key_in),
        .decrypt        (decrypt),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .key_parity_err (key_parity_err),
        .subkey         (subkey),
        .subkey_round   (subkey_round),
        .subkey_last    (subkey_last),
        .subkey_valid   (subkey_valid),
        .subkey_ready   (subkey_ready)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    // Subkey K(kNum), kNum=1..16, built from DES bit numbering: cd[j] is CD bit j+1.
    function automatic logic [47:0] modelSubkey(input logic [63:0] key, input int kNum);
        logic [27:0] c0;
        logic [27:0] d0;
        logic [55:0] cd;
        logic [47:0] k;
        int          cum;
        cum = 0;
        c0  = '0;
        d0  = '0;
        cd  = '0;
        k   = '0;
        for (int i = 0; i < kNum; i++) cum += ROTT[4'(i)];
        for (int j = 0; j < 28; j++) begin
            c0[5'(j)] = key[6'(64 - PC1T[6'(j)])];
            d0[5'(j)] = key[6'(64 - PC1T[6'(28 + j)])];
        end
        for (int j = 0; j < 28; j++) begin
            cd[6'(j)]      = c0[5'((j + cum) % 28)];
            cd[6'(28 + j)] = d0[5'((j + cum) % 28)];
        end
        for (int m = 0; m < 48; m++) k[6'(47 - m)] = cd[6'(PC2T[6'(m)] - 1)];
        return k;
    endfunction

    function automatic logic modelParity(input logic [63:0] key);
        logic [63:0] t;
        logic        err;
        t   = key;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if ($countones(t[7:0]) % 2 == 0) err = 1'b1;
            t = t >> 8;
        end
        return err;
    endfunction

    task automatic pushSchedule(input logic [63:0] key, input logic dec);
        for (int r = 0; r < 16; r++) begin
            exp_t e;
            e.key   = dec ? modelSubkey(key, 16 - r) : modelSubkey(key, r + 1);
            e.round = 4'(r);
            e.last  = (r == 15);
            expQ.push_back(e);
        end
    endtask

    // Scoreboard: every valid cycle must present the model's next subkey, held through stalls.
    always @(negedge clk) begin
        if (rst_n && subkey_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_valid", 64'd1, 64'd0);
            end else begin
                checkOutput("subkey", 64'(subkey), 64'(expQ[0].key));
                checkOutput("subkey_round", 64'(subkey_round), 64'(expQ[0].round));
                checkOutput("subkey_last", 64'(subkey_last), 64'(expQ[0].last));
                checkOutput("key_ready_busy", 64'(key_ready), 64'd0);
                if (subkey_ready) begin
                    if (subkey_round == 4'd0) capFirst = subkey;
                    if (subkey_last) capLast = subkey;
                    void'(expQ.pop_front());
                end
            end
        end
    end

    // One full key transaction: accept, drive ready pattern, optionally pulse junk keys or reset at abortRound.
    task automatic applyStimulus(input logic [63:0] key, input logic dec, input int stallPct,
                                 input bit junk, input int abortRound);
        int waitCyc;
        int cyc;
        waitCyc = 0;
        @(posedge clk); #1;
        while (!key_ready && waitCyc < 50) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        if (!key_ready) begin
            checkOutput("key_ready_timeout", 64'd0, 64'd1);
            return;
        end
        key_in       = key;
        decrypt      = dec;
        key_valid    = 1'b1;
        subkey_ready = ($urandom_range(99) >= 32'(stallPct));
        @(posedge clk); #1;
        key_valid = 1'b0;
        key_in    = {$urandom, $urandom};
        decrypt   = ~dec;
        pushSchedule(key, dec);
        checkOutput("parity_err", 64'(key_parity_err), 64'(modelParity(key)));
        checkOutput("first_subkey_latency", 64'(subkey_valid), 64'd1);
        cyc = 0;
        while (expQ.size() != 0 && cyc < 400) begin
            if (abortRound >= 0 && subkey_valid && subkey_round == 4'(abortRound)) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_valid", 64'(subkey_valid), 64'd0);
                checkOutput("abort_key_ready", 64'(key_ready), 64'd1);
                checkOutput("abort_subkey", 64'(subkey), 64'd0);
                checkOutput("abort_round", 64'(subkey_round), 64'd0);
                checkOutput("abort_parity", 64'(key_parity_err), 64'd0);
                expQ.delete();
                #2;
                rst_n = 1'b1;
                key_valid = 1'b0;
                return;
            end
            subkey_ready = ($urandom_range(99) >= 32'(stallPct));
            if (junk) begin
                key_valid = 1'($urandom_range(1));
                key_in    = {$urandom, $urandom};
                decrypt   = 1'($urandom_range(1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        key_valid = 1'b0;
        if (expQ.size() != 0) begin
            checkOutput("schedule_timeout", 64'(expQ.size()), 64'd0);
            expQ.delete();
        end
        if (stallPct == 0) checkOutput("no_bubble_cycles", 64'(cyc), 64'd16);
        checkOutput("done_valid", 64'(subkey_valid), 64'd0);
        checkOutput("done_key_ready", 64'(key_ready), 64'd1);
    endtask

    initial begin
        rst_n        = 1'b0;
        key_in       = '0;
        decrypt      = 1'b0;
        key_valid    = 1'b0;
        subkey_ready = 1'b0;
        capFirst     = '0;
        capLast      = '0;
        #12;
        checkOutput("reset_key_ready", 64'(key_ready), 64'd1);
        checkOutput("reset_valid", 64'(subkey_valid), 64'd0);
        checkOutput("reset_subkey", 64'(subkey), 64'd0);
        checkOutput("reset_round", 64'(subkey_round), 64'd0);
        checkOutput("reset_last", 64'(subkey_last), 64'd0);
        checkOutput("reset_parity", 64'(key_parity_err), 64'd0);
        #2;
        rst_n = 1'b1;

        // Pin the model with known-answer values.
        checkOutput("model_k1", 64'(modelSubkey(KEY_REF, 1)), 64'(K1_REF));
        checkOutput("model_k16", 64'(modelSubkey(KEY_REF, 16)), 64'(K16_REF));
        checkOutput("model_parity_ref", 64'(modelParity(KEY_REF)), 64'd0);
        checkOutput("model_parity_odd", 64'(modelParity(64'h0101010101010101)), 64'd0);
        checkOutput("model_parity_even", 64'(modelParity(64'h0001010101010101)), 64'd1);

        $display("[TB] encrypt, no stalls");
        applyStimulus(KEY_REF, 1'b0, 0, 1'b0, -1);
        checkOutput("enc_first", 64'(capFirst), 64'(K1_REF));
        checkOutput("enc_last", 64'(capLast), 64'(K16_REF));

        $display("[TB] decrypt, no stalls");
        applyStimulus(KEY_REF, 1'b1, 0, 1'b0, -1);
        checkOutput("dec_first", 64'(capFirst), 64'(K16_REF));
        checkOutput("dec_last", 64'(capLast), 64'(K1_REF));

        $display("[TB] stalls and ignored key pulses");
        applyStimulus(KEY_REF, 1'b0, 50, 1'b0, -1);
        applyStimulus(KEY_REF, 1'b1, 50, 1'b1, -1);
        for (int n = 0; n < 6; n++) begin
            applyStimulus({$urandom, $urandom}, 1'($urandom_range(1)), 50, 1'($urandom_range(1)), -1);
        end

        $display("[TB] parity keys");
        applyStimulus(64'h0101010101010101, 1'b0, 20, 1'b0, -1);
        applyStimulus(64'h0001010101010101, 1'b1, 20, 1'b0, -1);

        $display("[TB] reset mid-schedule");
        applyStimulus(KEY_REF, 1'b0, 30, 1'b0, 7);
        applyStimulus(KEY_REF, 1'b0, 0, 1'b0, -1);
        checkOutput("post_reset_first", 64'(capFirst), 64'(K1_REF));

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
